fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Fetch-stage program-counter unit of the 5-stage MIPS pipeline. It owns the F-stage PC register, selects the next PC (sequential, branch/jump, ERET, exception handler, reset), and produces the F-stage exception code and branch-delay flag. Its outputs feed the F-to-D pipeline register and the instruction-memory address port.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset
HANDLER_PC, 32'h0000_4180, PC loaded on exception/interrupt request
IM_BASE, 32'h0000_3000, lowest legal instruction address
IM_LIMIT, 32'h0000_6FFC, highest legal instruction address (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
Stall  in  1  hazard stall; hold the PC
Req  in  1  exception/interrupt redirect from CP0
D_eret  in  1  D-stage instruction is ERET
EPC  in  32  return address from CP0
D_jump  in  1  D-stage instruction is a branch/jump (taken or not)
D_redirect  in  1  D-stage branch/jump is taken
D_target  in  32  taken branch/jump target
F_pc  out  32  current fetch address; also the IM address
F_ExcCode  out  5  F-stage exception code: 0 none, 4 AdEL
F_BD  out  1  F-stage instruction is in a delay slot
flush  out  1  kill the F-stage instruction entering D (ERET)

Behaviour:
- One clock (clk). Synchronous active-high reset (reset). All state updates on the rising edge of clk.
- State is a single 32-bit pc register; F_pc = pc.
- Next-PC priority, highest first:
  1. reset: pc <= RESET_PC
  2. Req: pc <= HANDLER_PC (overrides Stall)
  3. Stall: pc holds
  4. D_eret: pc <= EPC
  5. D_redirect: pc <= D_target
  6. otherwise pc <= pc + 4, 32-bit wrap, no carry-out
- Reset values: F_pc = RESET_PC, F_ExcCode = 0, F_BD = 0, flush = 0 (outputs are derived from pc and inputs, which are quiescent at reset).
- F_ExcCode (combinational from pc): 4 (AdEL) if pc[1:0] != 0, or if pc < IM_BASE or pc > IM_LIMIT when the optional feature is enabled; otherwise 0.
- F_BD = D_jump & ~D_eret, regardless of Stall. The D-stage register captures F_BD only when not stalled.
- flush = D_eret & ~Stall & ~Req. The F-stage instruction fetched after ERET is not executed.
- Latency: a redirect input observed in cycle N appears on F_pc in cycle N+1.
- Simultaneous events:
  - D_eret and D_redirect both high: ERET wins (illegal encoding, but the result must be deterministic).
  - Stall with D_redirect or D_eret: hold the PC and keep flush low. D is held too, so the redirect is re-applied when the stall drops.
- A misaligned EPC or D_target is loaded as given; the AdEL is then raised on the following cycle from pc.
- reset asserted mid-stall or mid-redirect: pc <= RESET_PC, all pending redirects are dropped.

Optional Feature:
- Macro: FETCH_RANGE_CHECK_EN.
- When defined: AdEL is also raised for pc outside [IM_BASE, IM_LIMIT].
- When undefined: only misalignment raises AdEL, and IM_BASE/IM_LIMIT are unused.

Decomposition:
- Shared package (shared with the CP0 and pipeline registers): EXC_NONE = 5'd0, EXC_ADEL = 5'd4, RESET_PC and HANDLER_PC defaults.
- One sub-module, fetch_exc_check: combinational pc-to-ExcCode check, containing the FETCH_RANGE_CHECK_EN logic.

Test Plan:
- Reset is held, then released, and the unit runs 3 cycles -> F_pc 0x3000, 0x3004, 0x3008, 0x300C; F_ExcCode = 0 throughout.
- Stall held 2 cycles at pc 0x3008 -> F_pc stays 0x3008; on release, the next value is 0x300C.
- D_jump = 1, D_redirect = 1, D_target = 0x3100 at pc 0x3010 -> F_BD = 1 that cycle; next F_pc = 0x3100.
- Req = 1 while Stall = 1 at pc 0x3020 -> next F_pc = 0x4180. Separately, D_eret = 1 with EPC = 0x3040 -> flush = 1 and next F_pc = 0x3040.
- D_redirect with D_target = 0x3102 -> next cycle F_ExcCode = 4; F_pc = 0x3102 after one cycle; the following F_pc is 0x3106.
- D_target = 0x7000 (aligned) -> F_ExcCode = 4 with FETCH_RANGE_CHECK_EN defined, 0 without it.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_pkg
// Definitions shared by the fetch PC unit, CP0 and the pipeline registers:
//   EXC_NONE / EXC_ADEL      - exception codes carried down the pipeline
//   *_DEFAULT                - default reset / handler / IM window addresses
//   npc_sel_e                - next-PC source selector used by the fetch unit
// -----------------------------------------------------------------------------
package fetch_pc_unit_pkg;

   localparam logic [4:0]  EXC_NONE = 5'd0;
   localparam logic [4:0]  EXC_ADEL = 5'd4;

   localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
   localparam logic [31:0] IM_BASE_DEFAULT    = 32'h0000_3000;
   localparam logic [31:0] IM_LIMIT_DEFAULT   = 32'h0000_6FFC;

   typedef enum logic [2:0] {
      NPC_SEQ,
      NPC_HANDLER,
      NPC_HOLD,
      NPC_EPC,
      NPC_TARGET
   } npc_sel_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_if
// Bundle between the pipeline control (hazard unit, CP0, D stage) and the
// fetch PC unit.
//   master : drives Stall, Req, D_eret, EPC, D_jump, D_redirect, D_target;
//            receives F_pc, F_ExcCode, F_BD, flush
//   slave  : the fetch PC unit (mirror directions)
// -----------------------------------------------------------------------------
interface fetch_pc_if;

   logic        Stall;
   logic        Req;
   logic        D_eret;
   logic [31:0] EPC;
   logic        D_jump;
   logic        D_redirect;
   logic [31:0] D_target;
   logic [31:0] F_pc;
   logic [4:0]  F_ExcCode;
   logic        F_BD;
   logic        flush;

   modport master (
      output Stall, Req, D_eret, EPC, D_jump, D_redirect, D_target,
      input  F_pc, F_ExcCode, F_BD, flush
   );

   modport slave (
      input  Stall, Req, D_eret, EPC, D_jump, D_redirect, D_target,
      output F_pc, F_ExcCode, F_BD, flush
   );

endinterface

// File: rtl/fetch_pc_unit_exc_check.sv
// -----------------------------------------------------------------------------
// fetch_exc_check
// Combinational fetch-address check producing the F-stage exception code.
//   pc       in  32  current fetch address
//   exc_code out 5   EXC_ADEL on a bad fetch address, else EXC_NONE
// Macro FETCH_RANGE_CHECK_EN: when defined, addresses outside
// [IM_BASE, IM_LIMIT] also raise AdEL; otherwise only misalignment does.
// -----------------------------------------------------------------------------
module fetch_exc_check
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
   parameter logic [31:0] IM_LIMIT = IM_LIMIT_DEFAULT
) (
   input  logic [31:0] pc,
   output logic [4:0]  exc_code
);

   logic misaligned;
   logic out_of_range;

   assign misaligned = |pc[1:0];

`ifdef FETCH_RANGE_CHECK_EN
   assign out_of_range = (pc < IM_BASE) || (pc > IM_LIMIT);
`else
   // Window bounds and upper pc bits are intentionally ignored in this build.
   logic unused_range;
   assign unused_range = ^{IM_BASE, IM_LIMIT, pc[31:2]};
   assign out_of_range = 1'b0;
`endif

   assign exc_code = (misaligned || out_of_range) ? EXC_ADEL : EXC_NONE;

endmodule

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// F-stage program counter of the 5-stage MIPS pipeline. Owns the PC register,
// selects the next PC and produces the F-stage exception code, delay-slot flag
// and the ERET flush.
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset (pc <= RESET_PC)
//   fif    slave modport of fetch_pc_if:
//            Stall, Req, D_eret, EPC, D_jump, D_redirect, D_target (in)
//            F_pc, F_ExcCode, F_BD, flush (out)
// Macro FETCH_RANGE_CHECK_EN enables the IM window check (see fetch_exc_check).
// -----------------------------------------------------------------------------
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT,
   parameter logic [31:0] IM_BASE    = IM_BASE_DEFAULT,
   parameter logic [31:0] IM_LIMIT   = IM_LIMIT_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   fetch_pc_if.slave  fif
);

   logic [31:0] pc;
   logic [31:0] pc_next;
   npc_sel_e    npc_sel;

   // Req beats Stall (the redirect to the handler cannot wait); ERET beats a
   // taken branch so an illegal ERET+branch encoding still resolves one way.
   always_comb begin
      npc_sel = NPC_SEQ;
      if (fif.Req)             npc_sel = NPC_HANDLER;
      else if (fif.Stall)      npc_sel = NPC_HOLD;
      else if (fif.D_eret)     npc_sel = NPC_EPC;
      else if (fif.D_redirect) npc_sel = NPC_TARGET;
   end

   always_comb begin
      pc_next = pc + 32'd4;
      case (npc_sel)
         NPC_HANDLER: pc_next = HANDLER_PC;
         NPC_HOLD:    pc_next = pc;
         NPC_EPC:     pc_next = fif.EPC;
         NPC_TARGET:  pc_next = fif.D_target;
         default:     pc_next = pc + 32'd4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) pc <= RESET_PC;
      else       pc <= pc_next;
   end

   assign fif.F_pc = pc;

   // The D-stage register ignores F_BD while stalled, so no Stall gating here.
   assign fif.F_BD  = fif.D_jump & ~fif.D_eret;
   assign fif.flush = fif.D_eret & ~fif.Stall & ~fif.Req;

   fetch_exc_check #(
      .IM_BASE  (IM_BASE),
      .IM_LIMIT (IM_LIMIT)
   ) u_exc_check (
      .pc       (pc),
      .exc_code (fif.F_ExcCode)
   );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
// Scoreboard bench for fetch_pc_unit: the driver applies one input set per
// cycle and pushes the expected outputs; a monitor pops and compares on the
// falling edge. Honours FETCH_RANGE_CHECK_EN in its reference model.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

   localparam logic [31:0] T_RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] T_HANDLER_PC = 32'h0000_4180;
   localparam logic [31:0] T_IM_BASE    = 32'h0000_3000;
   localparam logic [31:0] T_IM_LIMIT   = 32'h0000_6FFC;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  exc;
      logic        bd;
      logic        flush;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   fetch_pc_if fif ();

   fetch_pc_unit #(
      .RESET_PC   (T_RESET_PC),
      .HANDLER_PC (T_HANDLER_PC),
      .IM_BASE    (T_IM_BASE),
      .IM_LIMIT   (T_IM_LIMIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .fif   (fif.slave)
   );

   always #5 clk = ~clk;

   exp_t        sb_q[$];
   int          n_compared = 0;
   int          n_mismatched = 0;
   logic [31:0] mpc;

   // Reference model: exception code from the address rules.
   function automatic logic [4:0] ref_exc(input logic [31:0] a);
      bit bad;
      bad = (a % 4) != 0;
`ifdef FETCH_RANGE_CHECK_EN
      if (a < T_IM_BASE || a > T_IM_LIMIT) bad = 1'b1;
`endif
      return bad ? 5'd4 : 5'd0;
   endfunction

   // Reference model: where fetch goes next, by the redirect priority list.
   function automatic logic [31:0] ref_next(input logic [31:0] a, input bit rst,
      input bit stall, input bit req, input bit eret, input bit redir,
      input logic [31:0] epc, input logic [31:0] tgt);
      if (rst)   return T_RESET_PC;
      if (req)   return T_HANDLER_PC;
      if (stall) return a;
      if (eret)  return epc;
      if (redir) return tgt;
      return 32'((64'(a) + 64'd4) % 64'h1_0000_0000);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: the unit presents a full output set every cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("F_pc", fif.F_pc, e.pc);
         chk("F_ExcCode", 32'(fif.F_ExcCode), 32'(e.exc));
         chk("F_BD", 32'(fif.F_BD), 32'(e.bd));
         chk("flush", 32'(fif.flush), 32'(e.flush));
      end
   end

   // One cycle of stimulus. With use_want the expected F_pc is the literal
   // want_pc instead of the running model value.
   task automatic step(input bit rst, input bit stall, input bit req, input bit eret,
      input bit jump, input bit redir, input logic [31:0] epc, input logic [31:0] tgt,
      input bit use_want, input logic [31:0] want_pc);
      exp_t e;
      reset          = rst;
      fif.Stall      = stall;
      fif.Req        = req;
      fif.D_eret     = eret;
      fif.D_jump     = jump;
      fif.D_redirect = redir;
      fif.EPC        = epc;
      fif.D_target   = tgt;
      e.pc    = use_want ? want_pc : mpc;
      e.exc   = ref_exc(e.pc);
      e.bd    = jump && !eret;
      e.flush = eret && !stall && !req;
      sb_q.push_back(e);
      @(posedge clk);
      mpc = ref_next(mpc, rst, stall, req, eret, redir, epc, tgt);
      #1;
   endtask

   task automatic dstep(input bit stall, input bit req, input bit eret, input bit jump,
      input bit redir, input logic [31:0] epc, input logic [31:0] tgt, input logic [31:0] want);
      step(1'b0, stall, req, eret, jump, redir, epc, tgt, 1'b1, want);
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 80) return T_IM_BASE + ({$urandom_range(0, 32'hFFF)} << 2);
      if (r < 90) return T_IM_BASE + 32'($urandom_range(0, 32'h3FFF));
      return $urandom();
   endfunction

   initial begin
      reset          = 1'b1;
      fif.Stall      = 1'b0;
      fif.Req        = 1'b0;
      fif.D_eret     = 1'b0;
      fif.D_jump     = 1'b0;
      fif.D_redirect = 1'b0;
      fif.EPC        = 32'h0;
      fif.D_target   = 32'h0;
      repeat (2) @(posedge clk);
      mpc = T_RESET_PC;
      #1;

      // Reset held, then release and run sequentially.
      step(1'b1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1'b1, 32'h3000);
      dstep(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h3000);
      dstep(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h3004);
      // Stall two cycles at 0x3008.
      dstep(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h3008);
      dstep(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h3008);
      dstep(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h3008);
      dstep(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h300C);
      // Taken jump at 0x3010: F_BD high, then 0x3100.
      dstep(0, 0, 0, 1, 1, 32'h0, 32'h3100, 32'h3010);
      dstep(0, 0, 0, 0, 1, 32'h0, 32'h3020, 32'h3100);
      // Req overrides Stall at 0x3020.
      dstep(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h3020);
      // ERET to 0x3040 with flush.
      dstep(0, 0, 1, 0, 0, 32'h3040, 32'h0, 32'h4180);
      // Misaligned target loads as given, then AdEL and +4.
      dstep(0, 0, 0, 0, 1, 32'h0, 32'h3102, 32'h3040);
      dstep(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h3102);
      dstep(0, 0, 0, 0, 1, 32'h0, 32'h7000, 32'h3106);
      // Aligned but above the IM window.
      dstep(0, 0, 0, 0, 1, 32'h0, 32'h3000, 32'h7000);
      // Stall with ERET pending: hold, no flush.
      dstep(1, 0, 1, 0, 0, 32'h3200, 32'h0, 32'h3000);
      // ERET and redirect together: ERET wins.
      dstep(0, 0, 1, 1, 1, 32'h3200, 32'h3300, 32'h3000);
      // Reset during a stalled redirect.
      step(1'b1, 1, 0, 0, 1, 1, 32'h0, 32'h3500, 1'b1, 32'h3200);
      dstep(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h3000);
      // Wrap-around of the sequential increment.
      dstep(0, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC, 32'h3004);
      dstep(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hFFFF_FFFC);
      dstep(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0000);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         bit r_rst, r_stall, r_req, r_eret, r_jump, r_redir;
         r_rst   = $urandom_range(0, 199) == 0;
         r_stall = $urandom_range(0, 99) < 20;
         r_req   = $urandom_range(0, 99) < 3;
         r_eret  = $urandom_range(0, 99) < 8;
         r_jump  = $urandom_range(0, 99) < 25;
         r_redir = r_jump ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 3);
         step(r_rst, r_stall, r_req, r_eret, r_jump, r_redir, rand_addr(), rand_addr(),
              1'b0, 32'h0);
      end

      @(negedge clk);
      #1;
      n_compared++;
      if (sb_q.size() != 0) begin
         n_mismatched++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
